dlfloat16_result_wb: RTL and testbench

//  Downstream writeback stage for the DLFloat16 FPU execution units (add, mul, cmp, sign-inv).

---
 rtl/dlfloat16_pkg.sv | 44 ++++
 rtl/dlfloat16_wb_fifo.sv | 56 +++++
 rtl/dlfloat16_result_wb.sv | 126 ++++++++++++
 tb/tb_dlfloat16_result_wb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlfloat16_pkg.sv
// Shared constants for the DLFloat16 FPU: unit-select codes, unit indices and
// exception flag bit positions.
package dlfloat16_pkg;

  localparam int NUM_UNITS  = 4;
  localparam int UNIT_IDX_W = 2;
  localparam int EXC_W      = 5;

  localparam logic [3:0] ENA_ADD = 4'b0001;
  localparam logic [3:0] ENA_MUL = 4'b0010;
  localparam logic [3:0] ENA_CMP = 4'b0100;
  localparam logic [3:0] ENA_SGN = 4'b0101;

  localparam logic [UNIT_IDX_W-1:0] UNIT_ADD = 2'd0;
  localparam logic [UNIT_IDX_W-1:0] UNIT_MUL = 2'd1;
  localparam logic [UNIT_IDX_W-1:0] UNIT_CMP = 2'd2;
  localparam logic [UNIT_IDX_W-1:0] UNIT_SGN = 2'd3;

  localparam int EXC_NV = 4;
  localparam int EXC_DZ = 3;
  localparam int EXC_OF = 2;
  localparam int EXC_UF = 1;
  localparam int EXC_NX = 0;

  typedef struct packed {
    logic                  hit;
    logic [UNIT_IDX_W-1:0] idx;
  } ena_dec_t;

  function automatic ena_dec_t decode_ena(input logic [3:0] ena);
    ena_dec_t d;
    d.hit = 1'b1;
    d.idx = UNIT_ADD;
    case (ena)
      ENA_ADD: d.idx = UNIT_ADD;
      ENA_MUL: d.idx = UNIT_MUL;
      ENA_CMP: d.idx = UNIT_CMP;
      ENA_SGN: d.idx = UNIT_SGN;
      default: d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dlfloat16_wb_fifo.sv
// Synchronous result FIFO with registered storage; head entry is read straight
// from the storage array so no input-to-output combinational path exists.
module dlfloat16_wb_fifo
  import dlfloat16_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 26
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dlfloat16_result_wb.sv
// Writeback stage for the DLFloat16 execution units: follows issued ops through
// the unit latency, captures the producing unit's result and queues it for the core.
module dlfloat16_result_wb
  import dlfloat16_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 5,
  parameter int UNIT_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [3:0]              issue_ena,
  input  logic [TAG_W-1:0]        issue_rd,
  input  logic [NUM_UNITS*32-1:0] unit_out,
  input  logic [NUM_UNITS*5-1:0]  unit_exc,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [TAG_W-1:0]        wb_rd,
  output logic [15:0]             wb_data,
  output logic [4:0]              wb_exc,
  output logic [4:0]              fflags,
  input  logic                    fflags_clr,
  output logic                    illegal_ena
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int OW    = CW + 1;
  localparam int WIDTH = TAG_W + 16 + EXC_W;

  logic                  pipe_v   [UNIT_LAT];
  logic [UNIT_IDX_W-1:0] pipe_idx [UNIT_LAT];
  logic [TAG_W-1:0]      pipe_rd  [UNIT_LAT];

  ena_dec_t              dec;
  logic                  fire;
  logic                  push;
  logic                  pop;
  logic [UNIT_IDX_W-1:0] exit_idx;
  logic [31:0]           slot_word;
  logic [EXC_W-1:0]      slot_exc;
  logic [WIDTH-1:0]      fifo_din;
  logic [WIDTH-1:0]      fifo_dout;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [OW-1:0]         occupancy;
  logic                  unused_hi;

  assign dec  = decode_ena(issue_ena);
  assign fire = issue_valid & issue_ready;

  // Ops still in the units are counted against FIFO space, so an issue is only
  // taken when its result is guaranteed a slot; same-cycle pops are not credited.
  always_comb begin
    occupancy = OW'(fifo_count);
    for (int unsigned i = 0; i < UNIT_LAT; i++) occupancy = occupancy + OW'(pipe_v[i]);
  end
  assign issue_ready = (occupancy < OW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < UNIT_LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_idx[i] <= '0;
        pipe_rd[i]  <= '0;
      end
      illegal_ena <= 1'b0;
    end else begin
      pipe_v[0]   <= fire & dec.hit;
      pipe_idx[0] <= dec.idx;
      pipe_rd[0]  <= issue_rd;
      for (int unsigned i = 1; i < UNIT_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
        pipe_rd[i]  <= pipe_rd[i-1];
      end
      illegal_ena <= fire & ~dec.hit;
    end
  end

  assign push     = pipe_v[UNIT_LAT-1];
  assign exit_idx = pipe_idx[UNIT_LAT-1];
  assign pop      = wb_valid & wb_ready;

  always_comb begin
    slot_word = unit_out[32*int'(exit_idx) +: 32];
    slot_exc  = unit_exc[5*int'(exit_idx) +: 5];
  end
  assign unused_hi = ^slot_word[31:16];
  assign fifo_din  = {pipe_rd[UNIT_LAT-1], slot_word[15:0], slot_exc};

  dlfloat16_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wb_valid                = ~fifo_empty;
  assign {wb_rd, wb_data, wb_exc} = fifo_dout;

  // Clear takes effect before the set from a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags <= '0;
    end else if (push) begin
      fflags <= (fflags_clr ? '0 : fflags) | slot_exc;
    end else if (fflags_clr) begin
      fflags <= '0;
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_dlfloat16_result_wb.sv
// Directed bench for dlfloat16_result_wb with a registered one-cycle unit model.
module tb_dlfloat16_result_wb;

  localparam int DEPTH    = 4;
  localparam int TAG_W    = 5;
  localparam int UNIT_LAT = 1;

  logic              clk;
  logic              rst_n;
  logic              issue_valid;
  logic              issue_ready;
  logic [3:0]        issue_ena;
  logic [TAG_W-1:0]  issue_rd;
  logic [4*32-1:0]   unit_out;
  logic [4*5-1:0]    unit_exc;
  logic              wb_valid;
  logic              wb_ready;
  logic [TAG_W-1:0]  wb_rd;
  logic [15:0]       wb_data;
  logic [4:0]        wb_exc;
  logic [4:0]        fflags;
  logic              fflags_clr;
  logic              illegal_ena;

  logic [31:0] unit_nxt [4];
  logic [4:0]  exc_nxt  [4];
  logic [3:0]  ena_tab  [4];

  int vectors;
  int miscompares;

  dlfloat16_result_wb #(
    .DEPTH    (DEPTH),
    .TAG_W    (TAG_W),
    .UNIT_LAT (UNIT_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_ena   (issue_ena),
    .issue_rd    (issue_rd),
    .unit_out    (unit_out),
    .unit_exc    (unit_exc),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_exc      (wb_exc),
    .fflags      (fflags),
    .fflags_clr  (fflags_clr),
    .illegal_ena (illegal_ena)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Execution units modelled as one register stage on their operands.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      unit_out[i*32 +: 32] <= unit_nxt[i];
      unit_exc[i*5 +: 5]   <= exc_nxt[i];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [3:0] ena, input logic [TAG_W-1:0] rd);
    issue_valid = 1'b1;
    issue_ena   = ena;
    issue_rd    = rd;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    vectors++; if ({wb_rd, wb_data, wb_exc} !== '0) begin miscompares++; $display("FAIL reset_wb_fields: got %h want 0", {wb_rd, wb_data, wb_exc}); end
    vectors++; if (fflags !== 5'b0) begin miscompares++; $display("FAIL reset_fflags: got %b want 00000", fflags); end
    vectors++; if (illegal_ena !== 1'b0) begin miscompares++; $display("FAIL reset_illegal: got %b want 0", illegal_ena); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sign_inv;
    wb_ready    = 1'b0;
    unit_nxt[3] = 32'h0000_BE00;
    drive_issue(4'b0101, 5'd3);
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL sgn_issue_ready: got %b want 1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL sgn_early_valid: got %b want 0", wb_valid); end
    tick();
    vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL sgn_valid: got %b want 1", wb_valid); end
    vectors++; if (wb_rd !== 5'd3) begin miscompares++; $display("FAIL sgn_rd: got %0d want 3", wb_rd); end
    vectors++; if (wb_data !== 16'hBE00) begin miscompares++; $display("FAIL sgn_data: got %h want be00", wb_data); end
    vectors++; if (wb_exc !== 5'b0) begin miscompares++; $display("FAIL sgn_exc: got %b want 00000", wb_exc); end
    tick();
    vectors++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd3, 16'hBE00}) begin miscompares++; $display("FAIL sgn_hold: got %b/%0d/%h want 1/3/be00", wb_valid, wb_rd, wb_data); end
    wb_ready = 1'b1;
    tick();
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL sgn_drain: got %b want 0", wb_valid); end
    wb_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    wb_ready    = 1'b1;
    unit_nxt[0] = 32'hFFFF_3C00;
    drive_issue(4'b0001, 5'd1);
    tick();
    unit_nxt[1] = 32'hABCD_4100;
    drive_issue(4'b0010, 5'd2);
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_early_valid: got %b want 0", wb_valid); end
    tick();
    issue_valid = 1'b0;
    vectors++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd1, 16'h3C00}) begin miscompares++; $display("FAIL b2b_first: got %b/%0d/%h want 1/1/3c00", wb_valid, wb_rd, wb_data); end
    tick();
    vectors++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd2, 16'h4100}) begin miscompares++; $display("FAIL b2b_second: got %b/%0d/%h want 1/2/4100", wb_valid, wb_rd, wb_data); end
    tick();
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty: got %b want 0", wb_valid); end
    wb_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      unit_nxt[i] = {16'h5A5A, 16'h1000 + 16'(i)};
      drive_issue(ena_tab[i], 5'(10 + i));
      vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_%0d: got %b want 1", i, issue_ready); end
      tick();
    end
    unit_nxt[0] = {16'h5A5A, 16'h1004};
    drive_issue(ena_tab[0], 5'd14);
    vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL bp_block_a: got %b want 0", issue_ready); end
    tick();
    vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL bp_block_b: got %b want 0", issue_ready); end
    wb_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vectors++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'(10 + k), 16'h1000 + 16'(k)}) begin miscompares++; $display("FAIL bp_pop_%0d: got %b/%0d/%h want 1/%0d/%h", k, wb_valid, wb_rd, wb_data, 10 + k, 16'h1000 + 16'(k)); end
      if (k == 1) begin
        vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL bp_reopen: got %b want 1", issue_ready); end
      end
      tick();
      if (k == 1) issue_valid = 1'b0;
    end
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty: got %b want 0", wb_valid); end
    wb_ready = 1'b0;
  endtask

  task automatic test_fflags;
    wb_ready   = 1'b1;
    exc_nxt[0] = 5'b00001;
    drive_issue(4'b0001, 5'd4);
    tick();
    exc_nxt[1] = 5'b10000;
    drive_issue(4'b0010, 5'd5);
    tick();
    issue_valid = 1'b0;
    vectors++; if (wb_exc !== 5'b00001) begin miscompares++; $display("FAIL ff_exc_add: got %b want 00001", wb_exc); end
    vectors++; if (fflags !== 5'b00001) begin miscompares++; $display("FAIL ff_first: got %b want 00001", fflags); end
    tick();
    vectors++; if (wb_exc !== 5'b10000) begin miscompares++; $display("FAIL ff_exc_mul: got %b want 10000", wb_exc); end
    vectors++; if (fflags !== 5'b10001) begin miscompares++; $display("FAIL ff_accum: got %b want 10001", fflags); end
    tick();
    exc_nxt[2] = 5'b00100;
    drive_issue(4'b0100, 5'd6);
    tick();
    issue_valid = 1'b0;
    fflags_clr  = 1'b1;
    tick();
    fflags_clr = 1'b0;
    vectors++; if (fflags !== 5'b00100) begin miscompares++; $display("FAIL ff_clr_push: got %b want 00100", fflags); end
    for (int i = 0; i < 4; i++) exc_nxt[i] = 5'b0;
    tick();
  endtask

  task automatic test_illegal;
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) exc_nxt[i] = 5'h1F;
    drive_issue(4'b1111, 5'd7);
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL ill_ready: got %b want 1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    vectors++; if (illegal_ena !== 1'b1) begin miscompares++; $display("FAIL ill_pulse: got %b want 1", illegal_ena); end
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL ill_valid_a: got %b want 0", wb_valid); end
    tick();
    vectors++; if (illegal_ena !== 1'b0) begin miscompares++; $display("FAIL ill_pulse_end: got %b want 0", illegal_ena); end
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL ill_valid_b: got %b want 0", wb_valid); end
    tick();
    vectors++; if (fflags !== 5'b00100) begin miscompares++; $display("FAIL ill_fflags: got %b want 00100", fflags); end
    for (int i = 0; i < 4; i++) exc_nxt[i] = 5'b0;
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    vectors++; if (fflags !== 5'b0) begin miscompares++; $display("FAIL ff_clr_alone: got %b want 00000", fflags); end
  endtask

  task automatic test_reset_flush;
    wb_ready   = 1'b0;
    exc_nxt[0] = 5'b00010;
    drive_issue(4'b0001, 5'd8);
    tick();
    drive_issue(4'b0010, 5'd9);
    tick();
    drive_issue(4'b0100, 5'd10);
    tick();
    issue_valid = 1'b0;
    vectors++; if ({wb_valid, fflags} !== {1'b1, 5'b00010}) begin miscompares++; $display("FAIL rf_pre: got %b/%b want 1/00010", wb_valid, fflags); end
    rst_n = 1'b0;
    #1;
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL rf_valid: got %b want 0", wb_valid); end
    vectors++; if (fflags !== 5'b0) begin miscompares++; $display("FAIL rf_fflags: got %b want 00000", fflags); end
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL rf_ready: got %b want 1", issue_ready); end
    exc_nxt[0] = 5'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if ({wb_valid, fflags} !== 6'b0) begin miscompares++; $display("FAIL rf_stale_%0d: got %b/%b want 0/00000", i, wb_valid, fflags); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_ena   = 4'b0;
    issue_rd    = '0;
    wb_ready    = 1'b0;
    fflags_clr  = 1'b0;
    ena_tab[0]  = 4'b0001;
    ena_tab[1]  = 4'b0010;
    ena_tab[2]  = 4'b0100;
    ena_tab[3]  = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      unit_nxt[i] = 32'h0;
      exc_nxt[i]  = 5'b0;
    end
    test_reset();
    test_sign_inv();
    test_back_to_back();
    test_backpressure();
    test_fflags();
    test_illegal();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
